// File: rtl/spi_pkg.sv
// Shared SPI initiator definitions: FSM state encoding, default geometry, bus mode.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV   = 4;

    // Mode 0: sclk idles low, data sampled on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } spiState_t;

endpackage

// File: rtl/sclk_tick_gen.sv
// Phase timer: one-clk tick every DIV cycles while en is high; clears when disabled.
// Latency: first tick DIV cycles after en rises.
// Backpressure: none; free-running while enabled.
module sclk_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] divCnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            divCnt <= '0;
        end else if (divCnt == CW'(DIV - 1)) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + CW'(1);
        end
    end

    assign tick = en && (divCnt == CW'(DIV - 1));

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator, MSB first; SPI_LOOPBACK_EN feeds the mosi register back into the receive path.
// Latency: done pulses DIV*(2*width+1) clks after the accepting edge.
// Backpressure: start is ignored while busy; host must wait for busy=0.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] txData,
    output logic [width-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = $clog2(width);

    spiState_t        state, stateNxt;
    logic             tick;
    logic             tickEn;
    logic [width-1:0] txShift, txShiftNxt;
    logic [width-1:0] rxShift, rxShiftNxt;
    logic [width-1:0] rxDataNxt;
    logic [BW-1:0]    bitCnt, bitCntNxt;
    logic             sclkNxt, csNxt, busyNxt, doneNxt;
    logic             sampleBit;
    logic             lastBit;

    assign tickEn  = (state != IDLE);
    assign lastBit = (bitCnt == BW'(width - 1));

    // mosi is the MSB of the registered shifter, so it only moves at acceptance or a falling edge.
    assign mosi = txShift[width-1];

`ifdef SPI_LOOPBACK_EN
    assign sampleBit = mosi;
`else
    assign sampleBit = miso;
`endif

    sclk_tick_gen #(.DIV(DIV)) uTickGen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tickEn),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = SETUP;
            SETUP:   if (tick)  stateNxt = HIGH;
            HIGH:    if (tick)  stateNxt = lastBit ? HOLD : LOW;
            LOW:     if (tick)  stateNxt = HIGH;
            HOLD:    if (tick)  stateNxt = IDLE;
            default:            stateNxt = IDLE;
        endcase
    end

    always_comb begin
        txShiftNxt = txShift;
        rxShiftNxt = rxShift;
        rxDataNxt  = rxData;
        bitCntNxt  = bitCnt;
        sclkNxt    = sclk;
        csNxt      = cs_n;
        busyNxt    = busy;
        doneNxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    txShiftNxt = txData;
                    csNxt      = 1'b0;
                    busyNxt    = 1'b1;
                    bitCntNxt  = '0;
                end
            end
            SETUP, LOW: begin
                if (tick) begin
                    sclkNxt    = ~CPOL;
                    rxShiftNxt = {rxShift[width-2:0], sampleBit};
                end
            end
            HIGH: begin
                if (tick) begin
                    sclkNxt = CPOL;
                    if (!lastBit) begin
                        txShiftNxt = txShift << 1;
                        bitCntNxt  = bitCnt + BW'(1);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    csNxt     = 1'b1;
                    busyNxt   = 1'b0;
                    doneNxt   = 1'b1;
                    rxDataNxt = rxShift;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txShift <= '0;
            rxShift <= '0;
            rxData  <= '0;
            bitCnt  <= '0;
            sclk    <= CPOL;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            txShift <= txShiftNxt;
            rxShift <= rxShiftNxt;
            rxData  <= rxDataNxt;
            bitCnt  <= bitCntNxt;
            sclk    <= sclkNxt;
            cs_n    <= csNxt;
            busy    <= busyNxt;
            done    <= doneNxt;
        end
    end

endmodule
